// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter controller for the instruction memory.
// Handles straight-line fetch, absolute branches, call/return through a
// hardware return stack, and halt. It reports run, done and fault status.
// Optional macro FETCH_SEQ_COUNT_EN adds a saturating retired-instruction counter.
`timescale 1ns/1ps
module fetch_sequencer #(
  parameter int unsigned PC_W        = 10,
  parameter int unsigned START_PC    = 0,
  parameter int unsigned SUB_BASE    = 100,
  parameter int unsigned SUB_STRIDE  = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic            jsr,
  input  logic [3:0]      jsr_idx,
  input  logic            rts,
  input  logic            br_taken,
  input  logic [7:0]      br_target,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            done,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [15:0]     instr_count
);

  localparam int unsigned AW  = $clog2(STACK_DEPTH);
  localparam int unsigned SPW = AW + 1;
  localparam logic [PC_W-1:0] START = PC_W'(START_PC);

  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic [PC_W-1:0] stack_q [STACK_DEPTH];
  logic [PC_W-1:0] stack_d [STACK_DEPTH];
  logic [1:0]      fc_q, fc_d;
  logic            running_q, done_q, fault_q;
  logic            stk_full, stk_empty;
  logic [PC_W-1:0] pc_inc, jsr_tgt;
  logic [AW-1:0]   top_idx;

  // Stack status, sequential address and subroutine entry point
  always_comb begin
    stk_full  = (sp_q == SPW'(STACK_DEPTH));
    stk_empty = (sp_q == '0);
    pc_inc    = pc_q + PC_W'(1);
    jsr_tgt   = PC_W'(SUB_BASE + 32'(jsr_idx) * SUB_STRIDE);
    top_idx   = sp_q[AW-1:0] - AW'(1);
  end

  // Next-state / next-pc selection, one action per unstalled RUN cycle
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    stack_d = stack_q;
    fc_d    = fc_q;
    case (state_q)
      IDLE: begin
        pc_d = START;
        if (start) begin
          state_d = RUN;
          sp_d    = '0;
          fc_d    = 2'd0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = HALT;
          end else if (rts) begin
            if (stk_empty) begin
              state_d = FAULT;
              fc_d    = 2'd2;
            end else begin
              pc_d = stack_q[top_idx];
              sp_d = sp_q - SPW'(1);
            end
          end else if (jsr) begin
            if (stk_full) begin
              state_d = FAULT;
              fc_d    = 2'd1;
            end else begin
              stack_d[sp_q[AW-1:0]] = pc_inc;
              sp_d = sp_q + SPW'(1);
              pc_d = jsr_tgt;
            end
          end else if (br_taken) begin
            pc_d = PC_W'(br_target);
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      HALT, FAULT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START;
          sp_d    = '0;
          fc_d    = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pc, stack and registered status decodes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= START;
      sp_q      <= '0;
      stack_q   <= '{default: '0};
      fc_q      <= 2'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      stack_q   <= stack_d;
      fc_q      <= fc_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == HALT);
      fault_q   <= (state_d == FAULT);
    end
  end

  assign pc         = pc_q;
  assign running    = running_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign fault_code = fc_q;

`ifdef FETCH_SEQ_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Retired-instruction count: saturating, cleared on start
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == RUN) begin
      if (!stall && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (start) begin
      cnt_d = 16'd0;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: fetch, branch, call/return, halt,
// stack faults, pc wrap, stall and mid-run reset.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, stall, jsr, rts, br_taken, halt;
  logic [3:0]  jsr_idx;
  logic [7:0]  br_target;
  logic [9:0]  pc;
  logic        running, done, fault;
  logic [1:0]  fault_code;
  logic [15:0] instr_count;

  int n_pass  = 0;
  int n_total = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .jsr(jsr), .jsr_idx(jsr_idx), .rts(rts), .br_taken(br_taken),
    .br_target(br_target), .halt(halt), .pc(pc), .running(running),
    .done(done), .fault(fault), .fault_code(fault_code),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef FETCH_SEQ_COUNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_st(input string tag, input logic [9:0] epc,
                        input logic er, input logic ed, input logic ef, input logic [1:0] ec);
    chk({tag, "_pc"}, 32'(pc), 32'(epc));
    chk({tag, "_run"}, 32'(running), 32'(er));
    chk({tag, "_done"}, 32'(done), 32'(ed));
    chk({tag, "_fault"}, 32'(fault), 32'(ef));
    chk({tag, "_code"}, 32'(fault_code), 32'(ec));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; jsr = 1'b0; jsr_idx = 4'd0;
    rts = 1'b0; br_taken = 1'b0; br_target = 8'd0; halt = 1'b0;
    step(); step();
    chk_st("reset", 10'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("reset_cnt", 32'(instr_count), 32'd0);

    // Strobes ignored in IDLE
    rst_n = 1'b1; jsr = 1'b1; br_taken = 1'b1; br_target = 8'd50;
    step();
    chk_st("idle", 10'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    jsr = 1'b0; br_taken = 1'b0;

    // Start and straight-line fetch
    start = 1'b1; step(); start = 1'b0;
    chk_st("start", 10'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("seq%0d", i), 32'(pc), 32'(i));
    end
    chk("cnt5", 32'(instr_count), exp_cnt(5));

    // Call subroutine 0 from pc 9 and return from 112
    repeat (4) step();
    chk("pc9", 32'(pc), 32'd9);
    jsr = 1'b1; jsr_idx = 4'd0; step(); jsr = 1'b0;
    chk("jsr0", 32'(pc), 32'd100);
    repeat (12) step();
    chk("pc112", 32'(pc), 32'd112);
    rts = 1'b1; step(); rts = 1'b0;
    chk("rts10", 32'(pc), 32'd10);

    // Branches, then halt wins over a simultaneous branch
    br_taken = 1'b1; br_target = 8'd97; step();
    chk("br97", 32'(pc), 32'd97);
    br_target = 8'd9; step();
    chk("br9", 32'(pc), 32'd9);
    br_target = 8'd97; step(); br_taken = 1'b0;
    step();
    chk("pc98", 32'(pc), 32'd98);
    halt = 1'b1; br_taken = 1'b1; br_target = 8'd9; step();
    halt = 1'b0; br_taken = 1'b0;
    chk_st("halt", 10'd98, 1'b0, 1'b1, 1'b0, 2'd0);
    jsr = 1'b1; rts = 1'b1; step(); jsr = 1'b0; rts = 1'b0;
    chk_st("halt_sticky", 10'd98, 1'b0, 1'b1, 1'b0, 2'd0);

    // Restart from HALT; LIFO order of two nested calls
    start = 1'b1; step(); start = 1'b0;
    chk_st("restart", 10'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    jsr = 1'b1; jsr_idx = 4'd1; step();
    chk("jsr1", 32'(pc), 32'd116);
    jsr_idx = 4'd2; step(); jsr = 1'b0;
    chk("jsr2", 32'(pc), 32'd132);
    rts = 1'b1; step();
    chk("rts117", 32'(pc), 32'd117);
    step(); rts = 1'b0;
    chk("rts1", 32'(pc), 32'd1);

    // Nesting beyond four levels overflows; rts+jsr together favours rts
    jsr = 1'b1;
    jsr_idx = 4'd1; step(); chk("nest1", 32'(pc), 32'd116);
    jsr_idx = 4'd2; step(); chk("nest2", 32'(pc), 32'd132);
    jsr_idx = 4'd3; step(); chk("nest3", 32'(pc), 32'd148);
    jsr_idx = 4'd4; step(); chk("nest4", 32'(pc), 32'd164);
    jsr_idx = 4'd5; step(); jsr = 1'b0;
    chk_st("ovf", 10'd164, 1'b0, 1'b0, 1'b1, 2'd1);
    step();
    chk_st("ovf_sticky", 10'd164, 1'b0, 1'b0, 1'b1, 2'd1);
    start = 1'b1; step(); start = 1'b0;
    chk_st("ovf_clear", 10'd0, 1'b1, 1'b0, 1'b0, 2'd0);

    // Highest subroutine index, then wrap 1023 -> 0
    jsr = 1'b1; jsr_idx = 4'd15; step(); jsr = 1'b0;
    chk("jsr15", 32'(pc), 32'd340);
    repeat (683) step();
    chk("pc1023", 32'(pc), 32'd1023);
    step();
    chk("wrap", 32'(pc), 32'd0);

    // Halt, restart, stall with jsr held: nothing changes
    halt = 1'b1; step(); halt = 1'b0;
    chk("halt0", 32'(done), 32'd1);
    start = 1'b1; step(); start = 1'b0;
    chk("cnt_clr", 32'(instr_count), exp_cnt(0));
    step(); step();
    chk("pc2", 32'(pc), 32'd2);
    stall = 1'b1; jsr = 1'b1; jsr_idx = 4'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_pc%0d", i), 32'(pc), 32'd2);
      chk($sformatf("stall_cnt%0d", i), 32'(instr_count), exp_cnt(2));
    end
    stall = 1'b0; jsr = 1'b0; step();
    chk("post_stall", 32'(pc), 32'd3);
    chk("post_stall_cnt", 32'(instr_count), exp_cnt(3));

    // Stack is still empty after the stalled jsr: rts underflows
    rts = 1'b1; step(); rts = 1'b0;
    chk_st("unf", 10'd3, 1'b0, 1'b0, 1'b1, 2'd2);

    // start in RUN is ignored; reset mid-run aborts to IDLE
    start = 1'b1; step();
    chk("unf_clear", 32'(fault_code), 32'd0);
    step(); start = 1'b0;
    chk("start_in_run", 32'(pc), 32'd1);
    rst_n = 1'b0; step();
    chk_st("midrst", 10'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("midrst_cnt", 32'(instr_count), 32'd0);
    rst_n = 1'b1; jsr = 1'b1; step(); jsr = 1'b0;
    chk_st("post_rst", 10'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
